// File: rtl/risc_v_mike_pkg.sv
// Shared GPIO definitions: register indices, the index enum and the default width.
package risc_v_mike_pkg;

    // Legacy GPIO_ENABLED build uses one byte of pins.
    localparam int GPIO_BYTE  = 8;
    localparam int GPIO_BUS_W = 32;

    localparam logic [2:0] GPIO_IDX_DATA_OUT   = 3'd0;
    localparam logic [2:0] GPIO_IDX_DATA_IN    = 3'd1;
    localparam logic [2:0] GPIO_IDX_DIR        = 3'd2;
    localparam logic [2:0] GPIO_IDX_IRQ_EN     = 3'd3;
    localparam logic [2:0] GPIO_IDX_IRQ_RISE   = 3'd4;
    localparam logic [2:0] GPIO_IDX_IRQ_FALL   = 3'd5;
    localparam logic [2:0] GPIO_IDX_IRQ_STATUS = 3'd6;

    typedef enum logic [2:0] {
        GPIO_REG_DATA_OUT   = GPIO_IDX_DATA_OUT,
        GPIO_REG_DATA_IN    = GPIO_IDX_DATA_IN,
        GPIO_REG_DIR        = GPIO_IDX_DIR,
        GPIO_REG_IRQ_EN     = GPIO_IDX_IRQ_EN,
        GPIO_REG_IRQ_RISE   = GPIO_IDX_IRQ_RISE,
        GPIO_REG_IRQ_FALL   = GPIO_IDX_IRQ_FALL,
        GPIO_REG_IRQ_STATUS = GPIO_IDX_IRQ_STATUS,
        GPIO_REG_UNMAPPED   = 3'd7
    } gpio_reg_idx_t;

endpackage

// File: rtl/risc_v_mike_gpio_sync.sv
// Multi-flop synchroniser for asynchronous pin inputs; q is the last stage.
module risc_v_mike_gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the pins through STAGES flops; stage 0 is the metastable one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain <= '0;
        else      chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/risc_v_mike_gpio_ctrl.sv
// Memory-mapped GPIO controller: direction/data registers, synchronised inputs,
// per-pin edge interrupts with W1C status and a post-reset settle window.
module risc_v_mike_gpio_ctrl
    import risc_v_mike_pkg::*;
#(
    parameter int GPIO_WIDTH  = GPIO_BYTE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            bus_addr,
    input  logic                  bus_wr_en,
    input  logic [31:0]           bus_wdata,
    input  logic                  bus_rd_en,
    output logic [31:0]           bus_rdata,
    output logic                  bus_rdata_valid,
    input  logic [GPIO_WIDTH-1:0] gpio_port_in,
    output logic [GPIO_WIDTH-1:0] gpio_port_out,
    output logic [GPIO_WIDTH-1:0] gpio_port_oe,
    output logic                  irq
);

    localparam logic [2:0] SETTLE_LAST = 3'(SYNC_STAGES + 1);

    gpio_reg_idx_t         reg_idx;
    logic [GPIO_WIDTH-1:0] wval;
    logic [GPIO_WIDTH-1:0] data_out, dir, irq_en, irq_rise, irq_fall, irq_status;
    logic [GPIO_WIDTH-1:0] sync_in, prev_in, data_in;
    logic [GPIO_WIDTH-1:0] rise, fall, edge_evt, w1c, rd_val;
    logic [2:0]            settle_cnt;
    logic                  settled;
    logic                  unused_bits;

    // Byte-lane bits of the address and wdata above the pin count carry no meaning.
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    assign reg_idx = gpio_reg_idx_t'(bus_addr[4:2]);
    assign wval    = bus_wdata[GPIO_WIDTH-1:0];

    risc_v_mike_gpio_sync #(
        .WIDTH  (GPIO_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_port_in),
        .q   (sync_in)
    );

    // Output pins loop back to DATA_IN; input pins read the synchronised value.
    assign data_in = (dir & data_out) | (~dir & sync_in);

    assign rise     = sync_in & ~prev_in;
    assign fall     = ~sync_in & prev_in;
    assign settled  = (settle_cnt == SETTLE_LAST);
    assign edge_evt = ((rise & irq_rise) | (fall & irq_fall)) & ~dir & {GPIO_WIDTH{settled}};

    // Control registers: written on the strobe edge; RO/unmapped indices ignore writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            dir      <= '0;
            irq_en   <= '0;
            irq_rise <= '0;
            irq_fall <= '0;
        end else if (bus_wr_en) begin
            case (reg_idx)
                GPIO_REG_DATA_OUT:  data_out <= wval;
                GPIO_REG_DIR:       dir      <= wval;
                GPIO_REG_IRQ_EN:    irq_en   <= wval;
                GPIO_REG_IRQ_RISE:  irq_rise <= wval;
                GPIO_REG_IRQ_FALL:  irq_fall <= wval;
                default: ;
            endcase
        end
    end

    // W1C mask for the status register; zero unless this cycle writes IRQ_STATUS.
    always_comb begin
        w1c = '0;
        if (bus_wr_en && reg_idx == GPIO_REG_IRQ_STATUS) w1c = wval;
    end

    // Sticky status: a new edge event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq_status <= '0;
        else      irq_status <= (irq_status & ~w1c) | edge_evt;
    end

    // Edge history tracks sync_in even while events are being suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_in <= '0;
        else      prev_in <= sync_in;
    end

    // Settle window: masks edges from the sync chain filling up after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          settle_cnt <= '0;
        else if (!settled) settle_cnt <= settle_cnt + 3'd1;
    end

    // Read mux sees pre-write register values, so read+write returns old data.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            GPIO_REG_DATA_OUT:   rd_val = data_out;
            GPIO_REG_DATA_IN:    rd_val = data_in;
            GPIO_REG_DIR:        rd_val = dir;
            GPIO_REG_IRQ_EN:     rd_val = irq_en;
            GPIO_REG_IRQ_RISE:   rd_val = irq_rise;
            GPIO_REG_IRQ_FALL:   rd_val = irq_fall;
            GPIO_REG_IRQ_STATUS: rd_val = irq_status;
            default:             rd_val = '0;
        endcase
    end

    // One-cycle read pipe; rdata holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rdata       <= '0;
            bus_rdata_valid <= 1'b0;
        end else begin
            bus_rdata_valid <= bus_rd_en;
            if (bus_rd_en) bus_rdata <= 32'(rd_val);
        end
    end

    assign gpio_port_out = data_out;
    assign gpio_port_oe  = dir;
    assign irq           = |(irq_status & irq_en);

endmodule

// File: doc/risc_v_mike_gpio_ctrl.md
RISC_V_MIKE_GPIO_CTRL -- requirements
Module: risc_v_mike_gpio_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst.
REQ-002 Parameter GPIO_WIDTH, default 8, number of GPIO pins (1..32).
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  asynchronous active-low reset.
REQ-006 Port bus_addr  input  5  byte address; bits [4:2] select register; bits [1:0] ignored.
REQ-007 Port bus_wr_en  input  1  write strobe, one cycle per write.
REQ-008 Port bus_wdata  input  32  write data; bits above GPIO_WIDTH ignored.
REQ-009 Port bus_rd_en  input  1  read strobe.
REQ-010 Port bus_rdata  output  32  read data; zero-extended above GPIO_WIDTH.
REQ-011 Port bus_rdata_valid  output  1  high exactly one cycle after an accepted bus_rd_en.
REQ-012 Port gpio_port_in  input  GPIO_WIDTH  asynchronous pin inputs.
REQ-013 Port gpio_port_out  output  GPIO_WIDTH  pin output values.
REQ-014 Port gpio_port_oe  output  GPIO_WIDTH  per-pin output enable (1 = drive).
REQ-015 Port irq  output  1  level interrupt request.

Function
REQ-016 Register map (index = addr[4:2]): 0 DATA_OUT RW; 1 DATA_IN RO; 2 DIR RW; 3 IRQ_EN RW; 4 IRQ_RISE RW (rising-edge select); 5 IRQ_FALL RW (falling-edge select); 6 IRQ_STATUS W1C; 7 unmapped.
REQ-017 Writes SHALL take effect on the clk edge where bus_wr_en is high; writes to DATA_IN or index 7 are ignored.
REQ-018 Reads SHALL have one-cycle latency: bus_rdata is registered and valid with bus_rdata_valid; index 7 reads 0; bus_rdata holds its value when bus_rdata_valid is low.
REQ-019 Simultaneous bus_wr_en and bus_rd_en to the same register SHALL return the pre-write value.
REQ-020 gpio_port_out SHALL equal DATA_OUT; gpio_port_oe SHALL equal DIR.
REQ-021 gpio_port_in SHALL pass through a SYNC_STAGES flop chain; sync_in is the last stage.
REQ-022 DATA_IN bit i SHALL read DATA_OUT[i] when DIR[i]=1, else sync_in[i].
REQ-023 A registered copy prev_in of sync_in SHALL be kept; rise[i] = sync_in[i] & ~prev_in[i]; fall[i] = ~sync_in[i] & prev_in[i].
REQ-024 IRQ_STATUS[i] SHALL set when (rise[i] & IRQ_RISE[i]) | (fall[i] & IRQ_FALL[i]) and DIR[i]=0, independent of IRQ_EN.
REQ-025 Writing 1 to an IRQ_STATUS bit SHALL clear it; if a set event occurs the same cycle, set wins.
REQ-026 irq SHALL equal |(IRQ_STATUS & IRQ_EN), combinational from registers.
REQ-027 A settle counter SHALL suppress edge events for SYNC_STAGES+1 cycles after reset release, counting up from 0 and saturating; prev_in still updates during suppression.

Reset
REQ-028 On rst low, all registers, sync chain, prev_in, settle counter and bus_rdata SHALL clear to 0 asynchronously: gpio_port_out=0, gpio_port_oe=0, irq=0, bus_rdata_valid=0.
REQ-029 Reset asserted mid-transaction SHALL abort it; no write completes and no bus_rdata_valid follows.

Structure
REQ-030 Register index constants (GPIO_IDX_DATA_OUT..GPIO_IDX_IRQ_STATUS) and a gpio_reg_idx_t enum SHALL live in risc_v_mike_pkg.
REQ-031 The synchroniser SHALL be a sub-module risc_v_mike_gpio_sync, parametrised by WIDTH and STAGES.
REQ-032 GPIO_WIDTH=8 SHALL be drop-in for the existing GPIO_ENABLED build (GPIO_BYTE).

Verification
REQ-033 Write DIR=0xFF, DATA_OUT=0xA5 -> gpio_port_oe=0xFF, gpio_port_out=0xA5 next cycle; read DATA_IN returns 0xA5 with bus_rdata_valid one cycle after bus_rd_en.
REQ-034 DIR=0, gpio_port_in 0x00->0x01 -> DATA_IN reads 0x01 no earlier than SYNC_STAGES cycles after the change.
REQ-035 IRQ_RISE=0x01, IRQ_EN=0x01, pin0 rises -> IRQ_STATUS=0x01, irq=1; write IRQ_STATUS=0x01 -> irq=0 next cycle.
REQ-036 W1C of bit 0 in same cycle as a new pin0 rising event -> IRQ_STATUS[0] stays 1.
REQ-037 gpio_port_in=0xFF held through reset release with IRQ_RISE=0xFF -> no IRQ_STATUS bits set.
REQ-038 Reset asserted during a pending read -> bus_rdata_valid stays 0; all outputs 0; read of index 7 after reset returns 0x00000000.
